// File: rtl/pwm_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder_pkg
// Purpose  : Shared definitions for the PWM receive path: duty-cycle width and
//            full-scale value (common with the PWM generator) plus the
//            decoder state encoding.
// Revision : 1.0  initial release
// ============================================================================
package pwm_decoder_pkg;

    localparam int              PCT_W   = 7;
    localparam logic [PCT_W-1:0] PCT_MAX = 7'd100;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_decoder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder_sync_edge
// Purpose  : Two-flop synchronizer for the asynchronous PWM pin plus a rising
//            edge detector. level and rise become visible together, three
//            clocks after the pin changes.
// Ports    : clk    in  system clock
//            reset  in  synchronous active-high reset (clears the rise pulse)
//            din    in  asynchronous input
//            level  out synchronized level
//            rise   out one-clk pulse on a synchronized 0->1 transition
// Revision : 1.0  initial release
// ============================================================================
module pwm_decoder_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    // The chain is deliberately not reset: a line held high across reset
    // must not look like a fresh rising edge once reset is released.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[1:0], din};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= 1'b0;
        end else begin
            rise <= sync_q[1] & ~sync_q[2];
        end
    end

    assign level = sync_q[2];

endmodule
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Measures an incoming PWM waveform on the one_MHz_enable time base
//            and reports its duty cycle as integer percent 0..100 (floor).
//            A constant line is reported as 0 or 100 after TIMEOUT ticks.
// Config   : PWM_DECODER_PERIOD_CHECK_EN - when defined, a sticky period_err
//            flags any locked period outside PERIOD +/- TOLERANCE; otherwise
//            period_err is tied low.
// Ports    : clk, reset (sync, active high), one_MHz_enable (tick),
//            pwm_in (async), duty_cycle[6:0], valid (pulse), locked,
//            period_err
// Revision : 1.0  initial release
// ============================================================================
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int PERIOD         = 1000,
    parameter int ONE_PCT_PERIOD = 10,
    parameter int TIMEOUT        = 2000,
    parameter int TOLERANCE      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_MHz_enable,
    input  logic             pwm_in,
    output logic [PCT_W-1:0] duty_cycle,
    output logic             valid,
    output logic             locked,
    output logic             period_err
);

    // Counter must reach TIMEOUT and also hold an over-long period for the
    // optional period comparison.
    localparam int              CNT_LIMIT = max_int(TIMEOUT, PERIOD + TOLERANCE);
    localparam int              CNT_W     = $clog2(CNT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(ONE_PCT_PERIOD - 1);
    localparam logic [PCT_W-1:0] PCT_ONE   = PCT_W'(1);

    logic level;
    logic rise;

    pwm_decoder_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .level (level),
        .rise  (rise)
    );

    state_t           state, state_nxt;
    logic [CNT_W-1:0] period_cnt, period_nxt;
    logic [CNT_W-1:0] frac_cnt, frac_nxt;
    logic [PCT_W-1:0] high_pct, pct_nxt;
    logic             rise_pend;
    logic             rise_evt;
    logic             timeout_hit;
    logic             restart;
    logic             report;
    logic             report_to;

    // A rise seen between ticks is held until the next tick so that edge
    // handling stays on the tick time base.
    assign rise_evt    = (rise | rise_pend) & one_MHz_enable;
    assign timeout_hit = one_MHz_enable & ~rise_evt & (period_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        report    = 1'b0;
        report_to = 1'b0;
        if (rise_evt) begin
            restart   = 1'b1;
            state_nxt = MEASURE;
            report    = (state == MEASURE);
        end else if (timeout_hit) begin
            state_nxt = ACQUIRE;
            report_to = 1'b1;
        end
    end

    // Counter update: a restart clears first, then the same tick counts as
    // the first tick of the new period.
    always_comb begin
        period_nxt = period_cnt;
        frac_nxt   = frac_cnt;
        pct_nxt    = high_pct;
        if (timeout_hit) begin
            period_nxt = '0;
            frac_nxt   = '0;
            pct_nxt    = '0;
        end else if (one_MHz_enable) begin
            if (restart) begin
                period_nxt = '0;
                frac_nxt   = '0;
                pct_nxt    = '0;
            end
            if (period_nxt != CNT_MAX) begin
                period_nxt = period_nxt + CNT_ONE;
            end
            if ((state_nxt == MEASURE) && level) begin
                if (frac_nxt == FRAC_LAST) begin
                    frac_nxt = '0;
                    if (pct_nxt < PCT_MAX) begin
                        pct_nxt = pct_nxt + PCT_ONE;
                    end
                end else begin
                    frac_nxt = frac_nxt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            frac_cnt   <= '0;
            high_pct   <= '0;
            rise_pend  <= 1'b0;
            duty_cycle <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            period_cnt <= period_nxt;
            frac_cnt   <= frac_nxt;
            high_pct   <= pct_nxt;
            rise_pend  <= (rise_pend | rise) & ~one_MHz_enable;
            valid      <= report | report_to;
            if (report) begin
                duty_cycle <= high_pct;
                locked     <= 1'b1;
            end else if (report_to) begin
                duty_cycle <= level ? PCT_MAX : '0;
                locked     <= 1'b0;
            end
        end
    end

`ifdef PWM_DECODER_PERIOD_CHECK_EN
    logic period_bad;

    assign period_bad = (int'(period_cnt) > PERIOD + TOLERANCE) ||
                        (int'(period_cnt) < PERIOD - TOLERANCE);

    // Only periods bounded by two tracked rises are judged.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_err <= 1'b0;
        end else if (report && locked && period_bad) begin
            period_err <= 1'b1;
        end
    end
`else
    assign period_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_decoder
// Purpose  : Directed self-checking bench for pwm_decoder (PERIOD=100,
//            ONE_PCT_PERIOD=1, TIMEOUT=200, tick every clock).
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_MHz_enable;
    logic       pwm_in;
    logic [6:0] duty_cycle;
    logic       valid;
    logic       locked;
    logic       period_err;

    int n_cmp = 0;
    int n_bad = 0;
    int nvalid;
    int last_duty;
    int exp_err;

    always #1 clk = ~clk;

    pwm_decoder #(
        .PERIOD         (100),
        .ONE_PCT_PERIOD (1),
        .TIMEOUT        (200),
        .TOLERANCE      (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .one_MHz_enable (one_MHz_enable),
        .pwm_in         (pwm_in),
        .duty_cycle     (duty_cycle),
        .valid          (valid),
        .locked         (locked),
        .period_err     (period_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then drive the pin.
    task automatic cyc(input logic p);
        @(negedge clk);
        if (valid === 1'b1) begin
            nvalid++;
            last_duty = int'(duty_cycle);
        end
        pwm_in = p;
    endtask

    task automatic pwm_period(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            cyc(i < h);
        end
    endtask

    initial begin
`ifdef PWM_DECODER_PERIOD_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        reset          = 1'b1;
        one_MHz_enable = 1'b1;
        pwm_in         = 1'b0;
        nvalid         = 0;
        last_duty      = -1;
        repeat (5) @(negedge clk);
        check("reset_duty",   32'(duty_cycle), 0);
        check("reset_valid",  32'(valid),      0);
        check("reset_locked", 32'(locked),     0);
        check("reset_err",    32'(period_err), 0);
        reset = 1'b0;

        // Loopback at 45%: first rise only arms, second reports.
        nvalid = 0;
        repeat (3) pwm_period(45, 100);
        check("d45_nvalid", 32'(nvalid), 2);
        check("d45_duty",   32'(last_duty), 45);
        check("d45_locked", 32'(locked), 1);

        // Duty sweep; 0% is only reported through the timeout path.
        for (int d = 0; d <= 90; d += 15) begin
            nvalid = 0;
            if (d == 0) begin
                repeat (2) pwm_period(0, 100);
            end else begin
                repeat (3) pwm_period(d, 100);
            end
            check($sformatf("sweep%0d_nvalid", d), 32'(nvalid), (d == 0) ? 1 : ((d == 15) ? 2 : 3));
            check($sformatf("sweep%0d_duty", d),   32'(last_duty), 32'(d));
            check($sformatf("sweep%0d_locked", d), 32'(locked), (d == 0) ? 0 : 1);
        end

        // Constant low, then constant high: timeout every 200 ticks.
        nvalid = 0;
        repeat (450) cyc(1'b0);
        check("hold0_nvalid", 32'(nvalid), 2);
        check("hold0_duty",   32'(last_duty), 0);
        check("hold0_locked", 32'(locked), 0);
        nvalid = 0;
        repeat (450) cyc(1'b1);
        check("hold1_nvalid", 32'(nvalid), 2);
        check("hold1_duty",   32'(last_duty), 100);
        check("hold1_locked", 32'(locked), 0);

        // Reset in the middle of a high phase at 60%.
        repeat (3) pwm_period(60, 100);
        repeat (30) cyc(1'b1);
        check("pre_rst_duty",   32'(last_duty), 60);
        check("pre_rst_locked", 32'(locked), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_duty",   32'(duty_cycle), 0);
        check("mid_rst_valid",  32'(valid), 0);
        check("mid_rst_locked", 32'(locked), 0);
        @(negedge clk);
        reset  = 1'b0;
        nvalid = 0;
        repeat (28) cyc(1'b1);
        repeat (40) cyc(1'b0);
        repeat (2) pwm_period(60, 100);
        check("post_rst_nvalid", 32'(nvalid), 1);
        check("post_rst_duty",   32'(last_duty), 60);
        check("post_rst_locked", 32'(locked), 1);

        // One 110-tick period among 100-tick periods.
        repeat (2) pwm_period(50, 100);
        check("pre_glitch_err", 32'(period_err), 0);
        pwm_period(50, 110);
        pwm_period(50, 100);
        check("glitch_err",  32'(period_err), 32'(exp_err));
        check("glitch_duty", 32'(last_duty), 50);
        repeat (2) pwm_period(50, 100);
        check("sticky_err",  32'(period_err), 32'(exp_err));

        // Time base stopped: the line toggles but nothing is counted.
        nvalid         = 0;
        one_MHz_enable = 1'b0;
        repeat (5) pwm_period(50, 100);
        check("frozen_nvalid", 32'(nvalid), 0);
        check("frozen_locked", 32'(locked), 1);
        check("frozen_duty",   32'(duty_cycle), 50);
        one_MHz_enable = 1'b1;
        repeat (3) pwm_period(50, 100);
        check("resume_duty",   32'(last_duty), 50);
        check("resume_locked", 32'(locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
